// File: rtl/dbg_probe_sampler_if.sv
// dbg_probe_sampler_if
//   Bundles the probe, control and overlay-facing signals of dbg_probe_sampler.
//   master : debug-tap / OSD side (drives probes and controls, reads results)
//   slave  : the sampler itself
// Signals
//   probe_in   CHANNELS*WIDTH  raw probe values, channel 0 in the LSBs
//   mode       2               0/3 live, 1 periodic, 2 trigger-freeze
//   trig_sel   SEL_W           channel compared for the trigger
//   trig_mask  WIDTH           trigger compare mask
//   trig_value WIDTH           trigger compare value
//   rearm      1               pulse: re-arm trigger, clear history
//   view       VIEW_W          history index, 0 = newest snapshot
//   probe_out  CHANNELS*WIDTH  value presented to the overlay
//   tick       1               one-cycle pulse at each periodic sample point
//   frozen     1               trigger fired, capture halted
//   valid_cnt  CNT_W           number of valid snapshots
interface dbg_probe_sampler_if #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4
);
  localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int VIEW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic [CHANNELS*WIDTH-1:0] probe_in;
  logic [1:0]                mode;
  logic [SEL_W-1:0]          trig_sel;
  logic [WIDTH-1:0]          trig_mask;
  logic [WIDTH-1:0]          trig_value;
  logic                      rearm;
  logic [VIEW_W-1:0]         view;
  logic [CHANNELS*WIDTH-1:0] probe_out;
  logic                      tick;
  logic                      frozen;
  logic [CNT_W-1:0]          valid_cnt;

  modport master (
    output probe_in, mode, trig_sel, trig_mask, trig_value, rearm, view,
    input  probe_out, tick, frozen, valid_cnt
  );

  modport slave (
    input  probe_in, mode, trig_sel, trig_mask, trig_value, rearm, view,
    output probe_out, tick, frozen, valid_cnt
  );
endinterface

// File: rtl/dbg_probe_sampler.sv
// dbg_probe_sampler
//   Debug probe sampler for the on-screen overlay. Registers CHANNELS probes of
//   WIDTH bits and presents them live, as periodic snapshots (one every DIV
//   cycles), or frozen on a masked trigger match. Snapshots go into a history
//   ring browsable through view.
// Ports
//   clk_sys  sole clock
//   reset_n  asynchronous active-low reset
//   bus      dbg_probe_sampler_if.slave (probes, controls, overlay outputs)
// Build option
//   PROBE_HISTORY_EN : defined -> DEPTH-entry ring, view honoured.
//                      undefined -> single snapshot register, view ignored,
//                      valid_cnt is 0 or 1.
module dbg_probe_sampler #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 16,
  parameter int DIV      = 5000000,
  parameter int DEPTH    = 4
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  dbg_probe_sampler_if.slave bus
);
  localparam int BUS_W  = CHANNELS * WIDTH;
  localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int TICK_W = $clog2(DIV);
  localparam logic [TICK_W-1:0] RELOAD = TICK_W'(DIV - 1);

  typedef enum logic {ARMED, FROZEN} trig_state_t;

  logic [BUS_W-1:0]  p_q;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_q;
  logic [1:0]        mode_q;
  logic              mode_seen;
  logic              mode_chg;
  logic              live_mode;
  logic              trig_mode;
  trig_state_t       state;
  trig_state_t       state_nx;
  logic [WIDTH-1:0]  sel_ch;
  logic              sel_hit;
  logic              match;
  logic              snap_wr;
  logic              frozen_c;
  logic [CNT_W-1:0]  valid_q;
  logic [BUS_W-1:0]  snap_rd;
  logic              snap_ok;

  assign live_mode = (bus.mode == 2'd0) || (bus.mode == 2'd3);
  assign trig_mode = (bus.mode == 2'd2);
  // mode_seen masks the first cycle after reset, where mode_q holds no real history.
  assign mode_chg  = mode_seen && (bus.mode != mode_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) p_q <= '0;
    else          p_q <= bus.probe_in;
  end

  // Tick is registered, so it rises DIV cycles after reset and the snapshot is
  // taken of p_q during the cycle tick is high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt  <= RELOAD;
      tick_q    <= 1'b0;
      mode_q    <= 2'd0;
      mode_seen <= 1'b0;
    end else begin
      mode_q    <= bus.mode;
      mode_seen <= 1'b1;
      if (mode_chg) begin
        tick_cnt <= RELOAD;
        tick_q   <= 1'b0;
      end else if (tick_cnt == '0) begin
        tick_cnt <= RELOAD;
        tick_q   <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt - TICK_W'(1);
        tick_q   <= 1'b0;
      end
    end
  end

  // Out-of-range selects leave sel_hit low, so they never match.
  always_comb begin
    sel_ch  = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.trig_sel == SEL_W'(i)) begin
        sel_ch  = p_q[i*WIDTH +: WIDTH];
        sel_hit = 1'b1;
      end
    end
  end

  assign match = trig_mode && (state == ARMED) && sel_hit &&
                 ((sel_ch & bus.trig_mask) == (bus.trig_value & bus.trig_mask));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ARMED;
    else          state <= state_nx;
  end

  // Rearm beats a coincident match; any mode other than 2 parks in ARMED.
  always_comb begin
    state_nx = state;
    if (bus.rearm || !trig_mode) state_nx = ARMED;
    else if (match)              state_nx = FROZEN;
  end

  // A match on a tick cycle still yields a single write.
  always_comb begin
    frozen_c = trig_mode && (state == FROZEN);
    snap_wr  = 1'b0;
    if (!bus.rearm) begin
      if (bus.mode == 2'd1)                   snap_wr = tick_q;
      else if (trig_mode && (state == ARMED)) snap_wr = tick_q | match;
    end
  end

`ifdef PROBE_HISTORY_EN
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [BUS_W-1:0] ring [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_idx;

  always_ff @(posedge clk_sys) begin
    if (snap_wr) ring[wr_ptr] <= p_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      valid_q <= '0;
    end else if (bus.rearm) begin
      wr_ptr  <= '0;
      valid_q <= '0;
    end else if (snap_wr) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (valid_q != FULL) valid_q <= valid_q + CNT_W'(1);
    end
  end

  // DEPTH is a power of two, so the pointer arithmetic wraps naturally.
  assign rd_idx  = wr_ptr - PTR_W'(1) - bus.view;
  assign snap_ok = CNT_W'(bus.view) < valid_q;
  assign snap_rd = ring[rd_idx];
`else
  logic [BUS_W-1:0] snap_q;
  logic             view_unused;

  always_ff @(posedge clk_sys) begin
    if (snap_wr) snap_q <= p_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)       valid_q <= '0;
    else if (bus.rearm) valid_q <= '0;
    else if (snap_wr)   valid_q <= CNT_W'(1);
  end

  assign view_unused = ^bus.view;
  assign snap_ok     = (valid_q != '0);
  assign snap_rd     = snap_q;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)       bus.probe_out <= '0;
    else if (live_mode) bus.probe_out <= p_q;
    else if (snap_ok)   bus.probe_out <= snap_rd;
    else                bus.probe_out <= '0;
  end

  assign bus.tick      = tick_q;
  assign bus.frozen    = frozen_c;
  assign bus.valid_cnt = valid_q;
endmodule

// File: tb/tb_dbg_probe_sampler.sv
// tb_dbg_probe_sampler
//   Directed bench for dbg_probe_sampler with CHANNELS=8, WIDTH=16, DIV=4,
//   DEPTH=4. Expectations follow the PROBE_HISTORY_EN setting of the build.
module tb_dbg_probe_sampler;
  localparam int CHANNELS = 8;
  localparam int WIDTH    = 16;
  localparam int DIV      = 4;
  localparam int DEPTH    = 4;
  localparam int BUS_W    = CHANNELS * WIDTH;

  typedef struct {
    logic [1:0]       view;
    logic [BUS_W-1:0] exp_out;
    logic [2:0]       exp_valid;
  } view_vec_t;

  logic clk_sys = 1'b0;
  logic reset_n;
  int   checks  = 0;
  int   errors  = 0;
  int   n;
  view_vec_t view_tab [4];

  dbg_probe_sampler_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dbg_probe_sampler #(
    .CHANNELS(CHANNELS),
    .WIDTH   (WIDTH),
    .DIV     (DIV),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [BUS_W-1:0] chan(input int idx, input logic [WIDTH-1:0] val);
    logic [BUS_W-1:0] r;
    r = '0;
    r[idx*WIDTH +: WIDTH] = val;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [BUS_W-1:0] act,
                              input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [BUS_W-1:0] p, input logic [1:0] m,
                                input logic r, input logic [1:0] v);
    bus.probe_in = p;
    bus.mode     = m;
    bus.rearm    = r;
    bus.view     = v;
  endtask

  // Counts falling edges until tick is seen high; a missing tick is a failure.
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk_sys);
      cnt++;
    end while (bus.tick !== 1'b1 && cnt < 20);
    if (bus.tick !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL tick timeout: got no tick, expected one within 20 cycles");
    end
  endtask

  initial begin
`ifdef PROBE_HISTORY_EN
    view_tab[0] = '{view: 2'd0, exp_out: chan(0, 16'd6), exp_valid: 3'd4};
    view_tab[1] = '{view: 2'd1, exp_out: chan(0, 16'd5), exp_valid: 3'd4};
    view_tab[2] = '{view: 2'd2, exp_out: chan(0, 16'd4), exp_valid: 3'd4};
    view_tab[3] = '{view: 2'd3, exp_out: chan(0, 16'd3), exp_valid: 3'd4};
`else
    view_tab[0] = '{view: 2'd0, exp_out: chan(0, 16'd6), exp_valid: 3'd1};
    view_tab[1] = '{view: 2'd1, exp_out: chan(0, 16'd6), exp_valid: 3'd1};
    view_tab[2] = '{view: 2'd2, exp_out: chan(0, 16'd6), exp_valid: 3'd1};
    view_tab[3] = '{view: 2'd3, exp_out: chan(0, 16'd6), exp_valid: 3'd1};
`endif

    reset_n        = 1'b0;
    bus.trig_sel   = '0;
    bus.trig_mask  = '0;
    bus.trig_value = '0;
    apply_stimulus('0, 2'd0, 1'b0, 2'd0);
    repeat (2) @(negedge clk_sys);
    check_output("reset probe_out", bus.probe_out, '0);
    check_output("reset tick", BUS_W'(bus.tick), '0);
    check_output("reset frozen", BUS_W'(bus.frozen), '0);
    check_output("reset valid_cnt", BUS_W'(bus.valid_cnt), '0);

    // Live mode: two-cycle latency, tick keeps running, ring untouched.
    reset_n = 1'b1;
    apply_stimulus(chan(3, 16'hA5C3), 2'd0, 1'b0, 2'd0);
    @(negedge clk_sys);
    check_output("live latency 1", bus.probe_out, '0);
    @(negedge clk_sys);
    check_output("live latency 2", bus.probe_out, chan(3, 16'hA5C3));
    wait_tick(n);
    check_output("first tick after reset", BUS_W'(2 + n), BUS_W'(DIV));
    @(negedge clk_sys);
    check_output("tick width", BUS_W'(bus.tick), '0);
    check_output("live valid_cnt", BUS_W'(bus.valid_cnt), '0);
    check_output("live hold", bus.probe_out, chan(3, 16'hA5C3));

    // Periodic mode: samples 1..6 on channel 0, one per tick.
    apply_stimulus(chan(0, 16'd1), 2'd1, 1'b0, 2'd0);
    @(negedge clk_sys);
    check_output("periodic empty", bus.probe_out, '0);
    wait_tick(n);
    check_output("periodic first tick", BUS_W'(n), BUS_W'(DIV));
    for (int k = 2; k <= 6; k++) begin
      apply_stimulus(chan(0, WIDTH'(k)), 2'd1, 1'b0, 2'd0);
      wait_tick(n);
      check_output("periodic period", BUS_W'(n), BUS_W'(DIV));
    end
    @(negedge clk_sys);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(chan(0, 16'd6), 2'd1, 1'b0, view_tab[i].view);
      @(negedge clk_sys);
      check_output("periodic view", bus.probe_out, view_tab[i].exp_out);
      check_output("periodic valid_cnt", BUS_W'(bus.valid_cnt), BUS_W'(view_tab[i].exp_valid));
    end

    // Trigger-freeze: channel 2, low byte 0x42, match lands off-tick.
    bus.trig_sel   = 3'd2;
    bus.trig_mask  = 16'h00FF;
    bus.trig_value = 16'h0042;
    apply_stimulus(chan(2, 16'h0000), 2'd2, 1'b0, 2'd0);
    @(negedge clk_sys);
    check_output("armed frozen", BUS_W'(bus.frozen), '0);
    apply_stimulus(chan(2, 16'h1342), 2'd2, 1'b0, 2'd0);
    @(negedge clk_sys);
    check_output("match cycle frozen", BUS_W'(bus.frozen), '0);
    @(negedge clk_sys);
    check_output("frozen after match", BUS_W'(bus.frozen), 1);
    @(negedge clk_sys);
    check_output("trigger snapshot", bus.probe_out, chan(2, 16'h1342));
`ifdef PROBE_HISTORY_EN
    check_output("trigger valid_cnt", BUS_W'(bus.valid_cnt), 4);
`else
    check_output("trigger valid_cnt", BUS_W'(bus.valid_cnt), 1);
`endif
    apply_stimulus(chan(2, 16'h1342), 2'd2, 1'b0, 2'd1);
    @(negedge clk_sys);
`ifdef PROBE_HISTORY_EN
    check_output("frozen view 1", bus.probe_out, chan(0, 16'd6));
`else
    check_output("frozen view 1", bus.probe_out, chan(2, 16'h1342));
`endif
    apply_stimulus(chan(2, 16'h7777), 2'd2, 1'b0, 2'd0);
    wait_tick(n);
    check_output("frozen tick period", BUS_W'(n), BUS_W'(DIV));
    wait_tick(n);
    @(negedge clk_sys);
    check_output("frozen hold probe_out", bus.probe_out, chan(2, 16'h1342));
    check_output("frozen hold flag", BUS_W'(bus.frozen), 1);

    // Rearm coincident with a match: rearm wins, a later match freezes again.
    apply_stimulus(chan(2, 16'h2242), 2'd2, 1'b0, 2'd0);
    @(negedge clk_sys);
    apply_stimulus(chan(2, 16'h1300), 2'd2, 1'b1, 2'd0);
    @(negedge clk_sys);
    apply_stimulus(chan(2, 16'h1300), 2'd2, 1'b0, 2'd0);
    check_output("rearm frozen", BUS_W'(bus.frozen), '0);
    check_output("rearm valid_cnt", BUS_W'(bus.valid_cnt), '0);
    @(negedge clk_sys);
    check_output("rearm no freeze", BUS_W'(bus.frozen), '0);
    apply_stimulus(chan(2, 16'h5542), 2'd2, 1'b0, 2'd0);
    @(negedge clk_sys);
    check_output("armed tick write", BUS_W'(bus.valid_cnt), 1);
    check_output("rematch not yet frozen", BUS_W'(bus.frozen), '0);
    @(negedge clk_sys);
    check_output("rematch frozen", BUS_W'(bus.frozen), 1);
`ifdef PROBE_HISTORY_EN
    check_output("rematch valid_cnt", BUS_W'(bus.valid_cnt), 2);
`else
    check_output("rematch valid_cnt", BUS_W'(bus.valid_cnt), 1);
`endif
    @(negedge clk_sys);
    check_output("rematch view 0", bus.probe_out, chan(2, 16'h5542));
    apply_stimulus(chan(2, 16'h5542), 2'd2, 1'b0, 2'd1);
    @(negedge clk_sys);
`ifdef PROBE_HISTORY_EN
    check_output("rematch view 1", bus.probe_out, chan(2, 16'h1300));
`else
    check_output("rematch view 1", bus.probe_out, chan(2, 16'h5542));
`endif
    apply_stimulus(chan(2, 16'h5542), 2'd2, 1'b0, 2'd2);
    @(negedge clk_sys);
`ifdef PROBE_HISTORY_EN
    check_output("view beyond valid", bus.probe_out, '0);
`else
    check_output("view beyond valid", bus.probe_out, chan(2, 16'h5542));
`endif

    // Asynchronous reset in the middle of periodic capture.
    apply_stimulus(chan(0, 16'h0BEE), 2'd1, 1'b0, 2'd0);
    @(negedge clk_sys);
    check_output("pre-reset probe_out", bus.probe_out, chan(2, 16'h5542));
    check_output("leave trig clears frozen", BUS_W'(bus.frozen), '0);
    @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check_output("async reset probe_out", bus.probe_out, '0);
    check_output("async reset tick", BUS_W'(bus.tick), '0);
    check_output("async reset frozen", BUS_W'(bus.frozen), '0);
    check_output("async reset valid_cnt", BUS_W'(bus.valid_cnt), '0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    wait_tick(n);
    check_output("tick after reset release", BUS_W'(n), BUS_W'(DIV));
    @(negedge clk_sys);
    check_output("post-reset before write", bus.probe_out, '0);
    @(negedge clk_sys);
    check_output("post-reset snapshot", bus.probe_out, chan(0, 16'h0BEE));
    check_output("post-reset valid_cnt", BUS_W'(bus.valid_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
